// File: rtl/roi_bin2x2_pkg.sv
// Shared types and default geometry constants for the ROI 2x2 binning stage.
package roi_pkg;

    localparam int WIDTH_DEF      = 1920;
    localparam int HEIGHT_DEF     = 1080;
    localparam int PIXEL_SIZE_DEF = 8;

    // Counter / buffer sizes for the default frame limits
    localparam int X_W      = $clog2(WIDTH_DEF);
    localparam int Y_W      = $clog2(HEIGHT_DEF);
    localparam int LB_DEPTH = WIDTH_DEF / 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_e;

    typedef logic [PIXEL_SIZE_DEF-1:0] pix_t;

endpackage

// File: rtl/roi_bin2x2_bin_line_buf.sv
// Simple dual-port line buffer: one write port, one registered read port.
// The read register holds its value until the next read, so it has no reset.
module bin_line_buf #(
    parameter int DEPTH = 960,
    parameter int DW    = 9
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [DW-1:0]            wdata_i,
    input  logic                     re_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [DW-1:0]            rdata_o
);

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rd_q, rd_d;

    // Read data is only refreshed when a read is issued
    always_comb begin
        rd_d = rd_q;
        if (re_i) rd_d = mem[raddr_i];
    end

    // Memory write and read register
    always_ff @(posedge clk) begin
        if (we_i) mem[waddr_i] <= wdata_i;
        rd_q <= rd_d;
    end

    assign rdata_o = rd_q;

endmodule

// File: rtl/roi_bin2x2.sv
// 2x2 binning of the cropped ROI stream: each output pixel is the rounded
// mean of one 2x2 block. Even rows store horizontal pair sums in a line
// buffer; odd rows add their own pair sum to the stored one.
module roi_bin2x2
    import roi_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int HEIGHT     = HEIGHT_DEF,
    parameter int PIXEL_SIZE = PIXEL_SIZE_DEF
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [$clog2(WIDTH)-1:0]  roi_start_x_i,
    input  logic [$clog2(HEIGHT)-1:0] roi_start_y_i,
    input  logic [$clog2(WIDTH)-1:0]  roi_end_x_i,
    input  logic [$clog2(HEIGHT)-1:0] roi_end_y_i,
    input  logic [PIXEL_SIZE-1:0]     data_i,
    input  logic                      valid_i,
    input  logic                      last_i,
    output logic [PIXEL_SIZE-1:0]     data_o,
    output logic                      valid_o,
    output logic                      last_o,
    output logic                      frame_err_o
);

    localparam int XW  = $clog2(WIDTH);
    localparam int YW  = $clog2(HEIGHT);
    localparam int LBD = WIDTH / 2;
    localparam int AW  = $clog2(LBD);
    localparam int PS  = PIXEL_SIZE;

    localparam logic [XW:0]   X_ONE = 1;
    localparam logic [YW:0]   Y_ONE = 1;
    localparam logic [PS+1:0] RND   = 2;

    state_e          state_q, state_d;
    logic [XW:0]     w_q, w_d, x_q, x_d;
    logic [YW:0]     h_q, h_d, y_q, y_d;
    logic [PS-1:0]   p_q, p_d;
    logic [PS-1:0]   data_q, data_d;
    logic            valid_q, valid_d, last_q, last_d, err_q, err_d;

    logic [XW:0]     w_now, x_last, x_blk_last;
    logic [YW:0]     h_now, y_last, y_blk_last, y_inc;
    logic [PS:0]     pair_sum, lb_rd;
    logic [PS+1:0]   total, rounded;
    logic            lb_we, lb_re, blk_done;

    // Geometry: live from the ROI inputs on a frame's first beat, latched after
    always_comb begin
        w_now      = (state_q == S_IDLE) ? ({1'b0, roi_end_x_i} - {1'b0, roi_start_x_i} + X_ONE) : w_q;
        h_now      = (state_q == S_IDLE) ? ({1'b0, roi_end_y_i} - {1'b0, roi_start_y_i} + Y_ONE) : h_q;
        x_last     = w_now - X_ONE;
        y_last     = h_now - Y_ONE;
        // Last column/row that still belongs to a complete 2x2 block
        x_blk_last = {w_now[XW:1], 1'b0} - X_ONE;
        y_blk_last = {h_now[YW:1], 1'b0} - Y_ONE;
        y_inc      = y_q + Y_ONE;
    end

    // Datapath: pair sums, line buffer control, rounded 4-pixel mean
    always_comb begin
        pair_sum = {1'b0, p_q} + {1'b0, data_i};
        lb_we    = valid_i & ~y_q[0] &  x_q[0];
        lb_re    = valid_i &  y_q[0] & ~x_q[0];
        blk_done = valid_i &  y_q[0] &  x_q[0];
        total    = {1'b0, lb_rd} + {1'b0, pair_sum};
        // Max 4*(2^PS-1)+2 still fits in PS+2 bits, so no overflow
        rounded  = total + RND;
    end

    // Frame FSM, counters and output staging
    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        h_d     = h_q;
        x_d     = x_q;
        y_d     = y_q;
        p_d     = p_q;
        data_d  = data_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        err_d   = 1'b0;
        if (valid_i) begin
            if (state_q == S_IDLE) begin
                w_d = w_now;
                h_d = h_now;
            end
            if (!x_q[0]) p_d = data_i;
            if (blk_done) begin
                valid_d = 1'b1;
                data_d  = rounded[PS+1:2];
                last_d  = (x_q == x_blk_last) && (y_q == y_blk_last);
            end
            if (last_i) begin
                state_d = S_IDLE;
                x_d     = '0;
                y_d     = '0;
                err_d   = !((x_q == x_last) && (y_q == y_last));
            end else if (x_q == x_last) begin
                x_d = '0;
                if (y_inc == h_now) begin
                    // Frame ran past its height without last_i
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    y_d     = '0;
                end else begin
                    y_d     = y_inc;
                    state_d = S_ACTIVE;
                end
            end else begin
                x_d     = x_q + X_ONE;
                state_d = S_ACTIVE;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            w_q     <= '0;
            h_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
            p_q     <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            w_q     <= w_d;
            h_q     <= h_d;
            x_q     <= x_d;
            y_q     <= y_d;
            p_q     <= p_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    bin_line_buf #(
        .DEPTH (LBD),
        .DW    (PS + 1)
    ) u_lb (
        .clk     (clk),
        .we_i    (lb_we),
        .waddr_i (x_q[AW:1]),
        .wdata_i (pair_sum),
        .re_i    (lb_re),
        .raddr_i (x_q[AW:1]),
        .rdata_o (lb_rd)
    );

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign last_o      = last_q;
    assign frame_err_o = err_q;

endmodule

// File: tb/tb_roi_bin2x2.sv
// Self-checking bench for roi_bin2x2: frame-level reference model of 2x2 binning.
module tb_roi_bin2x2;

    localparam int WIDTH  = 64;
    localparam int HEIGHT = 32;
    localparam int PS     = 8;
    localparam int XW     = $clog2(WIDTH);
    localparam int YW     = $clog2(HEIGHT);

    logic          clk = 1'b0;
    logic          rst_n;
    logic [XW-1:0] sx, ex;
    logic [YW-1:0] sy, ey;
    logic [PS-1:0] data_i;
    logic          valid_i, last_i;
    logic [PS-1:0] data_o;
    logic          valid_o, last_o, frame_err_o;

    roi_bin2x2 #(.WIDTH(WIDTH), .HEIGHT(HEIGHT), .PIXEL_SIZE(PS)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .roi_start_x_i (sx),
        .roi_start_y_i (sy),
        .roi_end_x_i   (ex),
        .roi_end_y_i   (ey),
        .data_i        (data_i),
        .valid_i       (valid_i),
        .last_i        (last_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .last_o        (last_o),
        .frame_err_o   (frame_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int d;
        bit l;
    } ob_t;

    int  n_cmp = 0;
    int  n_bad = 0;
    ob_t got_q[$];
    ob_t exp_q[$];
    ob_t last_got[$];
    int  pix[$];
    int  err_seen = 0;
    int  err_exp  = 0;

    // Capture outputs away from the active edge
    always @(negedge clk) begin
        ob_t t;
        if (rst_n) begin
            if (valid_o) begin
                t.d = int'(data_o);
                t.l = last_o;
                got_q.push_back(t);
            end
            if (frame_err_o) err_seen++;
        end
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: every 2x2 block whose fourth pixel was delivered yields its rounded mean
    task automatic model(input int w, input int h, input int npix);
        ob_t t;
        for (int by = 0; by < h / 2; by++)
            for (int bx = 0; bx < w / 2; bx++) begin
                int r0, r1;
                r0 = 2 * by * w + 2 * bx;
                r1 = r0 + w;
                if (r1 + 1 < npix) begin
                    t.d = (pix[r0] + pix[r0 + 1] + pix[r1] + pix[r1 + 1] + 2) / 4;
                    t.l = (by == h / 2 - 1) && (bx == w / 2 - 1);
                    exp_q.push_back(t);
                end
            end
        if (npix != w * h) err_exp++;
    endtask

    task automatic fill_rand(input int n);
        pix.delete();
        for (int i = 0; i < n; i++) pix.push_back(int'($urandom_range(255)));
    endtask

    // Drive one frame; ROI inputs are scrambled after the first beat
    task automatic send(input int w, input int h, input int npix, input int gap_pct, input bit use_last);
        int ox, oy;
        ox = int'($urandom_range(WIDTH - w));
        oy = int'($urandom_range(HEIGHT - h));
        sx = XW'(ox);
        ex = XW'(ox + w - 1);
        sy = YW'(oy);
        ey = YW'(oy + h - 1);
        for (int i = 0; i < npix; i++) begin
            while (i > 0 && int'($urandom_range(99)) < gap_pct) begin
                valid_i = 1'b0;
                last_i  = 1'b0;
                @(posedge clk); #1;
            end
            valid_i = 1'b1;
            data_i  = PS'(pix[i]);
            last_i  = use_last && (i == npix - 1);
            @(posedge clk); #1;
            if (i == 0) begin
                sx = XW'($urandom_range(WIDTH - 1));
                ex = XW'($urandom_range(WIDTH - 1));
                sy = YW'($urandom_range(HEIGHT - 1));
                ey = YW'($urandom_range(HEIGHT - 1));
            end
        end
        valid_i = 1'b0;
        last_i  = 1'b0;
    endtask

    task automatic check(input string tag);
        repeat (4) @(posedge clk);
        #1;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("%s_data%0d", tag, i), got_q[i].d, exp_q[i].d);
            chk($sformatf("%s_last%0d", tag, i), int'(got_q[i].l), int'(exp_q[i].l));
        end
        chk({tag, "_err"}, err_seen, err_exp);
        last_got = got_q;
        got_q.delete();
        exp_q.delete();
    endtask

    function automatic int got_d(input int i);
        return (i < last_got.size()) ? last_got[i].d : -1;
    endfunction

    initial begin
        rst_n = 1'b0; valid_i = 1'b0; last_i = 1'b0; data_i = '0;
        sx = '0; ex = '0; sy = '0; ey = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data",  int'(data_o), 0);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_last",  int'(last_o), 0);
        chk("rst_err",   int'(frame_err_o), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 4x2 directed frame
        pix = '{10, 20, 30, 40, 50, 60, 70, 80};
        model(4, 2, 8);
        send(4, 2, 8, 0, 1'b1);
        check("roi4x2");
        chk("roi4x2_o0", got_d(0), 35);
        chk("roi4x2_o1", got_d(1), 55);
        chk("roi4x2_last", (last_got.size() > 1) ? int'(last_got[1].l) : -1, 1);

        // Rounding
        pix = '{1, 1, 1, 2};
        model(2, 2, 4); send(2, 2, 4, 0, 1'b1); check("rnd_a");
        chk("rnd_a_val", got_d(0), 1);
        pix = '{1, 2, 2, 2};
        model(2, 2, 4); send(2, 2, 4, 0, 1'b1); check("rnd_b");
        chk("rnd_b_val", got_d(0), 2);
        pix = '{255, 255, 255, 255};
        model(2, 2, 4); send(2, 2, 4, 0, 1'b1); check("rnd_c");
        chk("rnd_c_val", got_d(0), 255);

        // 5x3 ramp: column 4 and row 2 dropped
        pix.delete();
        for (int i = 0; i < 15; i++) pix.push_back(i);
        model(5, 3, 15); send(5, 3, 15, 0, 1'b1); check("ramp5x3");
        chk("ramp_o0", got_d(0), 3);
        chk("ramp_o1", got_d(1), 5);

        // Back-to-back 4x4 frames with gaps
        fill_rand(16); model(4, 4, 16); send(4, 4, 16, 30, 1'b1);
        fill_rand(16); model(4, 4, 16); send(4, 4, 16, 30, 1'b1);
        check("b2b4x4");

        // Early last_i on pixel 10, then a good frame
        fill_rand(16); model(4, 4, 11); send(4, 4, 11, 0, 1'b1); check("early");
        fill_rand(16); model(4, 4, 16); send(4, 4, 16, 20, 1'b1); check("after_err");

        // Reset mid-frame after pixel 6
        fill_rand(16); send(4, 4, 7, 0, 1'b0);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("midrst_valid", int'(valid_o), 0);
            chk("midrst_data",  int'(data_o), 0);
            chk("midrst_last",  int'(last_o) + int'(frame_err_o), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        fill_rand(8); model(4, 2, 8); send(4, 2, 8, 0, 1'b1); check("post_rst");

        // Random geometries including degenerate widths/heights
        for (int k = 0; k < 12; k++) begin
            int w, h;
            w = int'($urandom_range(9, 1));
            h = int'($urandom_range(6, 1));
            fill_rand(w * h);
            model(w, h, w * h);
            send(w, h, w * h, int'($urandom_range(40)), 1'b1);
            check($sformatf("rand%0d", k));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/roi_bin2x2.md
Name: roi_bin2x2

Overview:
- Stage directly downstream of `roi`. Consumes the cropped ROI pixel stream (`data`/`valid`/`last`, no backpressure).
- Produces a 2x2-binned stream, half width and half height. Each output pixel is the rounded mean of one 2x2 block.
- Takes the same ROI corner inputs as `roi`, so it can derive the cropped frame geometry itself.

Parameters:
- WIDTH, 1920: maximum source frame width in pixels.
- HEIGHT, 1080: maximum source frame height in pixels.
- PIXEL_SIZE, 8: pixel width in bits.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  reset; asynchronous, active-low.
- roi_start_x_i  in  $clog2(WIDTH)  ROI first column, same value driven into `roi`.
- roi_start_y_i  in  $clog2(HEIGHT)  ROI first row.
- roi_end_x_i  in  $clog2(WIDTH)  ROI last column, inclusive.
- roi_end_y_i  in  $clog2(HEIGHT)  ROI last row, inclusive.
- data_i  in  PIXEL_SIZE  cropped pixel, raster order.
- valid_i  in  1  data_i qualifier; gaps allowed.
- last_i  in  1  marks the final pixel of the cropped frame.
- data_o  out  PIXEL_SIZE  binned pixel.
- valid_o  out  1  data_o qualifier.
- last_o  out  1  marks the final binned pixel of the frame.
- frame_err_o  out  1  one-cycle pulse on a frame length mismatch.

Behaviour:
- Reset (async, rst_n=0):
  - data_o, valid_o, last_o, frame_err_o all 0.
  - x, y counters 0; FSM in S_IDLE.
  - Line buffer contents are don't-care.
- Geometry:
  - w = end_x - start_x + 1 and h = end_y - start_y + 1, each carried in one extra bit.
  - Both are latched on the first valid_i beat of each frame (S_IDLE -> S_ACTIVE).
  - Changes to the ROI inputs mid-frame are ignored.
- FSM:
  - S_IDLE: waits for valid_i. On the first beat, latch geometry, process that pixel as (0,0), go to S_ACTIVE.
  - S_ACTIVE: on each valid_i beat, x increments. At x==w-1, x wraps to 0 and y increments.
  - A beat with last_i=1 returns to S_IDLE and clears x and y, whatever their position.
- Binning datapath (per valid beat only; valid_i=0 cycles change no state):
  - x even: hold data_i in pair register p.
  - x odd: pair sum s = p + data_i, PIXEL_SIZE+1 bits.
  - Even row, x odd: write s into line buffer at address x>>1.
  - Odd row, x even: issue a read at address x>>1. The registered read data holds until the next read, so valid_i gaps are tolerated.
  - Odd row, x odd: total = lb_rd + s, PIXEL_SIZE+2 bits; data_o = (total + 2) >> 2 (round half up, never overflows).
- Output timing:
  - valid_o=1 for exactly one cycle, on the clock edge after the beat that completes a block.
  - Latency is 1 clk from the block's fourth pixel to data_o.
- Dropped pixels:
  - Odd w: column w-1 is discarded.
  - Odd h: row h-1 is discarded.
  - w<2 or h<2: no output for the frame, and no error.
- last_o:
  - Asserted with the output of the block at row 2*(h/2)-1, column 2*(w/2)-1.
  - Generated from the counters, not from last_i.
- frame_err_o pulses 1 cycle after last_i when:
  - last_i arrives at any position other than (w-1, h-1), or
  - y reaches h without last_i. In that case, also force a return to S_IDLE.
- Simultaneous events:
  - last_i on a block-completing beat still emits that output.
  - The next frame's first beat may arrive on the very next cycle after last_i, with no bubble required.
- Reset mid-frame: the partial frame is abandoned. The first valid_i after reset release is treated as pixel (0,0).

Decomposition:
- Package roi_pkg holds:
  - localparams X_W = $clog2(WIDTH), Y_W = $clog2(HEIGHT), LB_DEPTH = WIDTH/2;
  - the FSM enum typedef {S_IDLE, S_ACTIVE};
  - typedef pix_t (PIXEL_SIZE bits).
- One sub-module, bin_line_buf: simple dual-port RAM, LB_DEPTH x (PIXEL_SIZE+1), one write port and one registered read port, no reset.

Test Plan:
- ROI 4x2, rows 10,20,30,40 / 50,60,70,80 -> outputs 35 then 55, last_o on 55, frame_err_o=0.
- Rounding: a block of 1,1,1,2 -> 1; a block of 1,2,2,2 -> 2; all 255 -> 255.
- ROI 5x3 ramp 0..14 -> 2 outputs from rows 0-1 only (3, 5); column 4 and row 2 dropped; last_o on 5; no error.
- Two back-to-back 4x4 frames, the second starting the cycle after last_i, with random valid_i gaps -> 4 outputs per frame, identical to the gap-free reference, last_o on each 4th.
- 4x4 frame with last_i on pixel 10 -> frame_err_o pulse; next 4x4 frame bins correctly.
- rst_n low after pixel 6 of a frame, then a full 4x2 frame -> all outputs 0 during reset; the 4x2 frame yields the correct 2 outputs.
